// File: rtl/leitor_sensores_pkg.sv
// Shared definitions for the sensor front end: FSM states, level codes
// and the level-code consistency check.
package leitor_sensores_pkg;

    typedef enum logic [1:0] {
        START = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } estado_t;

    // Level codes as {h,m,l}; a probe can only be wet if every probe below it is.
    localparam logic [2:0] NIVEL_VAZIO = 3'b000;
    localparam logic [2:0] NIVEL_BAIXO = 3'b001;
    localparam logic [2:0] NIVEL_MEDIO = 3'b011;
    localparam logic [2:0] NIVEL_CHEIO = 3'b111;

    function automatic logic nivel_valido(input logic [2:0] codigo);
        logic ok;
        case (codigo)
            NIVEL_VAZIO, NIVEL_BAIXO, NIVEL_MEDIO, NIVEL_CHEIO: ok = 1'b1;
            default:                                           ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/leitor_sensores_if.sv
// Sensor bundle: raw probe/status inputs in, clean registered signals out.
// There is no handshake: raw inputs may change at any time and are treated
// as asynchronous; outputs are registered and valid/err qualify l/m/h.
interface leitor_sensores_if;
    import leitor_sensores_pkg::*;

    logic    l_raw, m_raw, h_raw, vs_raw, bs_raw;
    logic    l, m, h, vs, bs;
    logic    valid, err;
    estado_t estado;   // debug view of the FSM state

    modport master (
        output l_raw, m_raw, h_raw, vs_raw, bs_raw,
        input  l, m, h, vs, bs, valid, err, estado
    );

    modport slave (
        input  l_raw, m_raw, h_raw, vs_raw, bs_raw,
        output l, m, h, vs, bs, valid, err, estado
    );
endinterface

// File: rtl/leitor_sensores_debounce_canal.sv
// One input channel: two-flop synchroniser followed by a debounce counter.
// A change is accepted only after DEB_CYCLES consecutive differing samples.
module debounce_canal #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_raw,
    output logic o_deb
);
    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_deb;
    logic [CW-1:0] r_cnt;

    // Synchronise, then count consecutive disagreements; any agreement restarts.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_deb   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_deb) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_MAX) begin
                r_deb <= r_sync2;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_deb = r_deb;
endmodule

// File: rtl/leitor_sensores.sv
// Sensor front end top: five debounced channels, the START/RUN/FAULT FSM,
// the held level code and the registered outputs.
module leitor_sensores
    import leitor_sensores_pkg::*;
#(
    parameter int DEB_CYCLES = 4
) (
    input logic               clk,
    input logic               rst_n,
    leitor_sensores_if.slave  bus
);
    // Startup wait long enough for a static input to cross sync + debounce.
    localparam int SW = $clog2(DEB_CYCLES + 3);
    localparam logic [SW-1:0] START_FIM = SW'(DEB_CYCLES + 2);

    logic [4:0]    w_raw;
    logic [4:0]    w_deb;
    logic [2:0]    w_codigo;
    logic          w_codigo_ok;
    estado_t       r_estado;
    estado_t       w_estado_next;
    logic [SW-1:0] r_start_cnt;
    logic [2:0]    r_nivel;
    logic          r_vs;
    logic          r_bs;

    // Channel order: l, m, h, vs, bs.
    assign w_raw = {bus.bs_raw, bus.vs_raw, bus.h_raw, bus.m_raw, bus.l_raw};

    for (genvar g = 0; g < 5; g++) begin : g_canal
        debounce_canal #(.DEB_CYCLES(DEB_CYCLES)) u_canal (
            .clk   (clk),
            .rst_n (rst_n),
            .i_raw (w_raw[g]),
            .o_deb (w_deb[g])
        );
    end

    assign w_codigo    = w_deb[2:0];
    assign w_codigo_ok = nivel_valido(w_codigo);

    // Next-state: leave START after the startup wait, then follow code validity.
    always_comb begin
        w_estado_next = r_estado;
        case (r_estado)
            START: begin
                if (r_start_cnt == START_FIM) begin
                    w_estado_next = w_codigo_ok ? RUN : FAULT;
                end
            end
            RUN:     if (!w_codigo_ok) w_estado_next = FAULT;
            FAULT:   if (w_codigo_ok)  w_estado_next = RUN;
            default: w_estado_next = START;
        endcase
    end

    // State register and startup counter (saturates at the end of the wait).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_estado    <= START;
            r_start_cnt <= '0;
        end else begin
            r_estado <= w_estado_next;
            if (r_estado == START && r_start_cnt != START_FIM) begin
                r_start_cnt <= r_start_cnt + 1'b1;
            end
        end
    end

    // Output registers: levels load only when entering/staying in RUN, so
    // FAULT keeps the last good code; status bits follow deb outside START.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_nivel <= NIVEL_VAZIO;
            r_vs    <= 1'b0;
            r_bs    <= 1'b0;
        end else begin
            if (w_estado_next == RUN) begin
                r_nivel <= w_codigo;
            end
            if (w_estado_next == START) begin
                r_vs <= 1'b0;
                r_bs <= 1'b0;
            end else begin
                r_vs <= w_deb[3];
                r_bs <= w_deb[4];
            end
        end
    end

    assign bus.l      = r_nivel[0];
    assign bus.m      = r_nivel[1];
    assign bus.h      = r_nivel[2];
    assign bus.vs     = r_vs;
    assign bus.bs     = r_bs;
    assign bus.valid  = (r_estado == RUN);
    assign bus.err    = (r_estado == FAULT);
    assign bus.estado = r_estado;
endmodule

// File: tb/tb_leitor_sensores.sv
// Bench for leitor_sensores: a DEB_CYCLES=4 and a DEB_CYCLES=1 instance share
// clock, reset and raw stimulus; both are compared every cycle against a
// behavioural model, plus directed timing checks from the test plan.
module tb_leitor_sensores;
    import leitor_sensores_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Raw stimulus, channel order l, m, h, vs, bs.
    logic [4:0] raw = 5'b00000;

    leitor_sensores_if bus4 ();
    leitor_sensores_if bus1 ();

    assign bus4.l_raw  = raw[0];
    assign bus4.m_raw  = raw[1];
    assign bus4.h_raw  = raw[2];
    assign bus4.vs_raw = raw[3];
    assign bus4.bs_raw = raw[4];
    assign bus1.l_raw  = raw[0];
    assign bus1.m_raw  = raw[1];
    assign bus1.h_raw  = raw[2];
    assign bus1.vs_raw = raw[3];
    assign bus1.bs_raw = raw[4];

    leitor_sensores #(.DEB_CYCLES(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
    leitor_sensores #(.DEB_CYCLES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    // ---------------- behavioural model ----------------
    // Mode: 0 = starting up, 1 = running, 2 = fault.
    int       deb_of [2] = '{4, 1};
    bit       m_s1   [2][5];
    bit       m_s2   [2][5];
    bit       m_deb  [2][5];
    bit [7:0] m_hist [2][5];   // recent synchronised samples, newest in bit 0
    int       m_mode [2];
    int       m_sc   [2];
    bit [2:0] m_lvl  [2];
    bit       m_vs   [2];
    bit       m_bs   [2];

    int n_vec = 0;
    int n_err = 0;

    function automatic bit code_ok(input bit [2:0] c);
        return (c == 3'b000) || (c == 3'b001) || (c == 3'b011) || (c == 3'b111);
    endfunction

    // Advance the model by one rising edge using pre-edge values.
    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                for (int c = 0; c < 5; c++) begin
                    m_s1[k][c] = 0; m_s2[k][c] = 0; m_deb[k][c] = 0; m_hist[k][c] = '0;
                end
                m_mode[k] = 0; m_sc[k] = 0; m_lvl[k] = 3'b000; m_vs[k] = 0; m_bs[k] = 0;
            end else begin
                bit [2:0] old_code;
                bit       old_vs, old_bs, ok;
                old_code = {m_deb[k][2], m_deb[k][1], m_deb[k][0]};
                old_vs   = m_deb[k][3];
                old_bs   = m_deb[k][4];
                ok       = code_ok(old_code);
                // A change is accepted once the last deb_of samples all disagree.
                for (int c = 0; c < 5; c++) begin
                    bit all_diff;
                    m_hist[k][c] = {m_hist[k][c][6:0], m_s2[k][c]};
                    all_diff = 1;
                    for (int i = 0; i < deb_of[k]; i++)
                        if (m_hist[k][c][i] == m_deb[k][c]) all_diff = 0;
                    if (all_diff) m_deb[k][c] = m_s2[k][c];
                end
                if (m_mode[k] == 0) begin
                    if (m_sc[k] == deb_of[k] + 2) m_mode[k] = ok ? 1 : 2;
                    else m_sc[k]++;
                end else begin
                    m_mode[k] = ok ? 1 : 2;
                end
                if (m_mode[k] == 1) m_lvl[k] = old_code;
                if (m_mode[k] != 0) begin
                    m_vs[k] = old_vs;
                    m_bs[k] = old_bs;
                end
                for (int c = 0; c < 5; c++) begin
                    m_s2[k][c] = m_s1[k][c];
                    m_s1[k][c] = raw[c];
                end
            end
        end
    endtask

    // ---------------- scoreboard ----------------
    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] obs_vec(input int k);
        if (k == 0)
            return {bus4.estado == START, bus4.estado == FAULT, bus4.valid, bus4.err,
                    bus4.bs, bus4.vs, bus4.h, bus4.m, bus4.l};
        return {bus1.estado == START, bus1.estado == FAULT, bus1.valid, bus1.err,
                bus1.bs, bus1.vs, bus1.h, bus1.m, bus1.l};
    endfunction

    function automatic logic [8:0] exp_vec(input int k);
        return {m_mode[k] == 0, m_mode[k] == 2, m_mode[k] == 1, m_mode[k] == 2,
                m_bs[k], m_vs[k], m_lvl[k]};
    endfunction

    // ---------------- driver ----------------
    // One clock: model follows the edge, outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("model_deb4", obs_vec(0), exp_vec(0));
        chk("model_deb1", obs_vec(1), exp_vec(1));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    logic [2:0] lvl_tab [4] = '{3'b000, 3'b001, 3'b011, 3'b111};

    initial begin
        // Reset with l wet, everything else dry.
        rst_n = 1'b0;
        raw   = 5'b00001;
        ticks(3);
        chk("reset_outputs", obs_vec(0), 9'b1_0000_0000);
        rst_n = 1'b1;
        ticks(6);
        chk("startup_valid_low", {8'b0, bus4.valid}, 9'd0);
        tick();
        chk("startup_valid_high", {8'b0, bus4.valid}, 9'd1);
        chk("startup_level", {6'b0, bus4.h, bus4.m, bus4.l}, 9'b001);
        chk("startup_err", {8'b0, bus4.err}, 9'd0);

        // Glitch of 3 cycles on m: filtered.
        raw[1] = 1'b1;
        ticks(3);
        raw[1] = 1'b0;
        ticks(10);
        chk("glitch3_m", {8'b0, bus4.m}, 9'd0);

        // 4-cycle pulse on m: accepted, then the fall is accepted too.
        raw[1] = 1'b1;
        ticks(4);
        raw[1] = 1'b0;
        ticks(2);
        chk("pulse4_before", {8'b0, bus4.m}, 9'd0);
        tick();
        chk("pulse4_rise", {8'b0, bus4.m}, 9'd1);
        ticks(3);
        chk("pulse4_still", {8'b0, bus4.m}, 9'd1);
        tick();
        chk("pulse4_fall", {8'b0, bus4.m}, 9'd0);
        ticks(4);

        // Inconsistent code 101, then repaired to 111.
        raw[2] = 1'b1;
        ticks(6);
        chk("fault_not_yet", {8'b0, bus4.err}, 9'd0);
        tick();
        chk("fault_err", {7'b0, bus4.err, bus4.valid}, 9'b10);
        chk("fault_hold", {6'b0, bus4.h, bus4.m, bus4.l}, 9'b001);
        raw[1] = 1'b1;
        ticks(7);
        chk("recover_flags", {7'b0, bus4.err, bus4.valid}, 9'b01);
        chk("recover_level", {6'b0, bus4.h, bus4.m, bus4.l}, 9'b111);

        // Status channels change together.
        raw[4:3] = 2'b11;
        ticks(6);
        chk("status_before", {7'b0, bus4.bs, bus4.vs}, 9'b00);
        tick();
        chk("status_after", {7'b0, bus4.bs, bus4.vs}, 9'b11);
        chk("status_levels", {6'b0, bus4.h, bus4.m, bus4.l}, 9'b111);

        // Settle at l only, then reset in the middle of an m debounce.
        raw = 5'b00001;
        ticks(12);
        raw[1] = 1'b1;
        ticks(2);
        rst_n = 1'b0;
        tick();
        chk("midreset_outputs", obs_vec(0), 9'b1_0000_0000);
        rst_n = 1'b1;
        ticks(6);
        chk("midreset_wait", {7'b0, bus4.m, bus4.valid}, 9'b00);
        tick();
        chk("midreset_level", {5'b0, bus4.valid, bus4.h, bus4.m, bus4.l}, 9'b1011);

        // DEB_CYCLES=1: a one-cycle vs pulse propagates after edge 3.
        raw[3] = 1'b1;
        tick();
        raw[3] = 1'b0;
        ticks(2);
        chk("deb1_before", {8'b0, bus1.vs}, 9'd0);
        tick();
        chk("deb1_pulse", {8'b0, bus1.vs}, 9'd1);
        tick();
        chk("deb1_after", {8'b0, bus1.vs}, 9'd0);
        ticks(8);

        // Randomised phase: mostly consistent level codes, random holds,
        // occasional resets; the model checks every cycle.
        for (int it = 0; it < 250; it++) begin
            if ($urandom_range(0, 39) == 0) begin
                rst_n = 1'b0;
                tick();
                rst_n = 1'b1;
            end else begin
                if ($urandom_range(0, 3) == 0) raw[2:0] = 3'($urandom_range(0, 7));
                else raw[2:0] = lvl_tab[$urandom_range(0, 3)];
                raw[4:3] = 2'($urandom_range(0, 3));
                ticks($urandom_range(1, 7));
            end
        end
        ticks(10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/leitor_sensores.md
# leitor_sensores

Input front end of the irrigation controller: samples the raw water-level probes (l, m, h) and the two status inputs (vs, bs), synchronises and debounces them, and checks that the level code is physically consistent. It produces the clean, registered sensor signals that the seven-segment decoders and the control logic consume. It also reports when they are trustworthy and when the probes disagree.

## Interface
- DEB_CYCLES, default 4: consecutive synchronised cycles a changed input must hold before it is accepted. Legal range 1..255.
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- l_raw, m_raw, h_raw  in  1 each  asynchronous level probes (low, medium, high)
- vs_raw, bs_raw  in  1 each  asynchronous status inputs
- l, m, h  out  1 each  validated level outputs
- vs, bs  out  1 each  debounced status outputs
- valid  out  1  outputs trustworthy (state RUN)
- err  out  1  level code inconsistent (state FAULT)

## Operation
- Reset (rst_n=0 at an edge):
  - All outputs go to 0.
  - Synchroniser flops, debounced registers, counters and the held level code are cleared.
  - FSM goes to START.
  - This applies identically mid-operation.
- Synchroniser: every raw input passes through two flops (sync1, sync2).
- Debounce, one independent channel per input, each with its own debounced register deb and counter cnt:
  - sync2 == deb: cnt <= 0.
  - sync2 != deb and cnt == DEB_CYCLES-1: deb <= sync2, cnt <= 0.
  - Otherwise: cnt <= cnt+1.
  - Any return to equality before acceptance discards the change.
- Valid level codes, as {h,m,l}: 000, 001, 011, 111. All others are invalid.
- FSM states:
  - START: valid=0, err=0. A startup counter runs DEB_CYCLES+2 cycles. It then goes to RUN if the debounced code is valid, else to FAULT.
  - RUN: valid=1. Each cycle the level outputs load the debounced code. If the debounced code is invalid, go to FAULT; the level outputs keep their previous value.
  - FAULT: err=1, valid=0. The level outputs hold the last valid code, or 000 if none has been seen since reset. Return to RUN on the first cycle the debounced code is valid; the outputs load it on that same edge.
- vs and bs outputs load deb every cycle in RUN and FAULT. They are held at 0 in START.
- Simultaneous changes on several channels are debounced independently. The consistency check always sees the current set of deb registers.

## Timing
- Raw change sampled at edge 0 reaches sync2 at edge 1.
  - deb updates at edge DEB_CYCLES+1.
  - The registered output updates at edge DEB_CYCLES+2.
  - With DEB_CYCLES=4, the output changes after edge 6.
- A pulse shorter than DEB_CYCLES cycles at sync2 never reaches the outputs.
- RUN to FAULT: err=1 one edge after deb first forms an invalid code. FAULT to RUN takes the same one edge.
- After reset release, valid rises no earlier than DEB_CYCLES+2 edges later.
- A reset asserted during a debounce in progress discards it.
- Counter width is clog2(DEB_CYCLES) with a minimum of 1. cnt never exceeds DEB_CYCLES-1.

## Structure
- Shared package holds:
  - FSM state typedef (START, RUN, FAULT).
  - Level-code constants: NIVEL_VAZIO=000, NIVEL_BAIXO=001, NIVEL_MEDIO=011, NIVEL_CHEIO=111.
  - The validity check function.
- Sub-module: debounce_canal, one-bit synchroniser plus debounce counter, parameterised by DEB_CYCLES. Instantiated five times.
- The top level holds the FSM, the held level code and the output registers.

## Test plan
- Reset then static inputs, DEB_CYCLES=4, l_raw=1 and others 0:
  - valid=0 for the first 6 edges after release, then 1.
  - {h,m,l}=001, err=0.
- Glitch: in RUN with {h,m,l}=001, m_raw pulses high for 3 cycles → no output change. A 4-cycle pulse → m=1 at edge 6 after the rise, then back to 0 after the fall plus 6 edges.
- Inconsistent code: drive h_raw=1 with m_raw=0, l_raw=1 →
  - err=1 and valid=0 one edge after deb updates.
  - {h,m,l} holds 001.
  - Raise m_raw → RUN, {h,m,l}=111, err=0.
- Status channels: vs_raw and bs_raw toggle simultaneously → both outputs change on the same edge, DEB_CYCLES+2 after sampling. Levels are unaffected.
- Reset mid-debounce: m_raw rises, rst_n=0 two cycles later → all outputs 0 and START. After release the full startup delay is observed before m=1.
- DEB_CYCLES=1 build: raw change appears on the output after edge 3. A one-cycle raw pulse that is caught in sync2 propagates.
